// File: rtl/img_uart_streamer.sv
// Streams an image from byte memory as one 8N1 UART frame. The frame is A5,
// the width and height (little-endian), the row-major pixels, then an 8-bit sum.
module img_uart_streamer #(
  parameter int AW           = 19,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   out_w,
  input  logic [15:0]   out_h,
  input  logic [AW-1:0] base_addr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          uart_tx,
  output logic          busy,
  output logic          done,
  output logic [31:0]   byte_count
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] SEND  = 3'd4;
  localparam logic [2:0] CSUM  = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  logic [2:0]    state_r;
  logic          busy_r, done_r, rd_en_r, csum_sent_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   byte_count_r, pix_rem_r;
  logic [7:0]    csum_r;
  logic [2:0]    hdr_idx_r;
  logic [15:0]   w_r, h_r;

  logic          tx_busy_r, tx_line_r;
  logic [CW-1:0] tx_cnt_r;
  logic [3:0]    tx_bit_r;
  logic [7:0]    tx_shift_r;

  logic          tx_last_s, tx_free_s, tx_load_s;
  logic [7:0]    tx_data_s, hdr_byte_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] pix);
    return acc + pix;
  endfunction

  // A new byte may be loaded on the very edge the current stop bit ends, so bytes run gap-free.
  assign tx_last_s = tx_busy_r && (tx_cnt_r == CNT_MAX) && (tx_bit_r == 4'd9);
  assign tx_free_s = !tx_busy_r || tx_last_s;

  // Header byte selected by position in the header.
  always_comb begin
    case (hdr_idx_r)
      3'd0:    hdr_byte_s = 8'hA5;
      3'd1:    hdr_byte_s = w_r[7:0];
      3'd2:    hdr_byte_s = w_r[15:8];
      3'd3:    hdr_byte_s = h_r[7:0];
      3'd4:    hdr_byte_s = h_r[15:8];
      default: hdr_byte_s = 8'h00;
    endcase
  end

  // Decide when the transmitter is handed a new byte and which byte it is.
  always_comb begin
    tx_load_s = 1'b0;
    tx_data_s = 8'h00;
    case (state_r)
      HDR: begin
        if (tx_free_s && (hdr_idx_r != 3'd5)) begin
          tx_load_s = 1'b1;
          tx_data_s = hdr_byte_s;
        end else begin
          tx_load_s = 1'b0;
        end
      end
      WAIT: begin
        tx_load_s = 1'b1;
        tx_data_s = mem_rdata;
      end
      CSUM: begin
        if (tx_free_s && !csum_sent_r) begin
          tx_load_s = 1'b1;
          tx_data_s = csum_r;
        end else begin
          tx_load_s = 1'b0;
        end
      end
      default: tx_load_s = 1'b0;
    endcase
  end

  // 8N1 serializer: bit slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      tx_busy_r  <= 1'b0;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= 1'b1;
    end else if (tx_load_s) begin
      tx_busy_r  <= 1'b1;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= tx_data_s;
      tx_line_r  <= 1'b0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == CNT_MAX) begin
        tx_cnt_r <= '0;
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          tx_line_r <= 1'b1;
        end else begin
          tx_bit_r  <= tx_bit_r + 4'd1;
          tx_line_r <= (tx_bit_r == 4'd8) ? 1'b1 : tx_shift_r[tx_bit_r[2:0]];
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      tx_line_r <= 1'b1;
    end
  end

  // Frame sequencer: header, one fetch/wait/send round per pixel, checksum, finish.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rd_en_r      <= 1'b0;
      addr_r       <= '0;
      byte_count_r <= 32'd0;
      csum_r       <= 8'h00;
      hdr_idx_r    <= 3'd0;
      csum_sent_r  <= 1'b0;
      w_r          <= 16'h0000;
      h_r          <= 16'h0000;
      pix_rem_r    <= 32'd0;
    end else begin
      if (tx_last_s) begin
        byte_count_r <= byte_count_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= HDR;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            byte_count_r <= 32'd0;
            csum_r       <= 8'h00;
            hdr_idx_r    <= 3'd0;
            csum_sent_r  <= 1'b0;
            w_r          <= out_w;
            h_r          <= out_h;
            addr_r       <= base_addr;
            pix_rem_r    <= {16'h0000, out_w} * {16'h0000, out_h};
          end
        end
        HDR: begin
          if (tx_free_s) begin
            if (hdr_idx_r != 3'd5) begin
              hdr_idx_r <= hdr_idx_r + 3'd1;
            end else if (pix_rem_r == 32'd0) begin
              state_r <= CSUM;
            end else begin
              state_r <= FETCH;
              rd_en_r <= 1'b1;
            end
          end
        end
        FETCH: begin
          rd_en_r <= 1'b0;
          state_r <= WAIT;
        end
        WAIT: begin
          csum_r  <= csum_add(csum_r, mem_rdata);
          state_r <= SEND;
        end
        SEND: begin
          if (tx_last_s) begin
            pix_rem_r <= pix_rem_r - 32'd1;
            if (pix_rem_r == 32'd1) begin
              state_r <= CSUM;
            end else begin
              state_r <= FETCH;
              rd_en_r <= 1'b1;
              addr_r  <= addr_r + ADDR_ONE;
            end
          end
        end
        CSUM: begin
          if (tx_free_s) begin
            if (!csum_sent_r) begin
              csum_sent_r <= 1'b1;
            end else begin
              state_r <= FIN;
            end
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign mem_addr   = addr_r;
  assign mem_rd_en  = rd_en_r;
  assign uart_tx    = tx_line_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_img_uart_streamer.sv
// Randomized and directed bench for img_uart_streamer: a UART decoder, a
// 1-cycle memory model and a frame-level reference model.
module tb_img_uart_streamer;
  localparam int AW   = 19;
  localparam int CPB  = 4;
  localparam int MASK = 32'h7FFFF;

  logic          clk_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   out_w = 16'h0000;
  logic [15:0]   out_h = 16'h0000;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata = 8'h00;
  logic          uart_tx, busy, done;
  logic [31:0]   byte_count;

  img_uart_streamer #(.AW(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .start(start), .out_w(out_w), .out_h(out_h),
    .base_addr(base_addr), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx), .busy(busy), .done(done),
    .byte_count(byte_count)
  );

  always #5 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [int];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int rd_q[$];
  int exp_rd_q[$];
  int bit_err = 0, max_gap = 0, gap_cnt = 0, dec_pos = -1;
  int done_rises = 0, sync_err = 0;
  bit have_prev = 1'b0;
  logic prev_busy = 1'b0, prev_done = 1'b0;
  logic [7:0] dec_byte = 8'h00;
  logic dec_bit = 1'b0;

  // Memory: data for a strobed address appears one cycle later, junk otherwise.
  initial forever begin
    @(posedge clk_50);
    if (mem_rd_en === 1'b1) begin
      rd_q.push_back(int'(mem_addr));
      mem_rdata <= mem_m.exists(int'(mem_addr)) ? mem_m[int'(mem_addr)] : 8'h00;
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // UART decoder sampling mid-cycle; every bit must hold for CPB samples.
  initial forever begin
    @(negedge clk_50);
    if (rst_n !== 1'b1) begin
      dec_pos = -1; have_prev = 1'b0; gap_cnt = 0;
    end else if (dec_pos < 0) begin
      if (uart_tx === 1'b0) begin
        if (have_prev && gap_cnt > max_gap) max_gap = gap_cnt;
        dec_pos = 1;
      end else begin
        gap_cnt++;
      end
    end else begin
      if (dec_pos / CPB == 0) begin
        if (uart_tx !== 1'b0) bit_err++;
      end else if (dec_pos / CPB <= 8) begin
        if (dec_pos % CPB == 0) begin
          dec_bit = uart_tx;
          dec_byte[dec_pos / CPB - 1] = uart_tx;
        end else if (uart_tx !== dec_bit) begin
          bit_err++;
        end
      end else begin
        if (uart_tx !== 1'b1) bit_err++;
      end
      dec_pos++;
      if (dec_pos == 10 * CPB) begin
        rx_q.push_back(dec_byte);
        dec_pos = -1; have_prev = 1'b1; gap_cnt = 0;
      end
    end
  end

  // Tracks done rising edges and whether busy ever falls without done rising.
  initial forever begin
    @(negedge clk_50);
    if (done === 1'b1 && prev_done === 1'b0) done_rises++;
    if (rst_n === 1'b1 && prev_busy === 1'b1 && busy === 1'b0 &&
        !(done === 1'b1 && prev_done === 1'b0)) sync_err++;
    prev_busy = busy;
    prev_done = done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [7:0] rx_at(input int i);
    if (i >= 0 && i < rx_q.size()) return rx_q[i];
    else return 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    if (i >= 0 && i < exp_q.size()) return exp_q[i];
    else return 8'hxx;
  endfunction

  function automatic int frame_diff();
    int n = (rx_q.size() > exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= rx_q.size() || i >= exp_q.size()) return i;
      if (rx_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic int addr_diff();
    int n = (rd_q.size() > exp_rd_q.size()) ? rd_q.size() : exp_rd_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= rd_q.size() || i >= exp_rd_q.size()) return i;
      if (rd_q[i] != exp_rd_q[i]) return i;
    end
    return -1;
  endfunction

  // Reference frame: header, pixels from (base+i) mod 2^AW, then sum mod 256.
  task automatic build_expected(input int w, input int h, input int base);
    int n;
    int sum;
    int a;
    logic [7:0] px;
    n = w * h;
    sum = 0;
    exp_q.delete();
    exp_rd_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(w % 256));
    exp_q.push_back(8'(w / 256));
    exp_q.push_back(8'(h % 256));
    exp_q.push_back(8'(h / 256));
    for (int i = 0; i < n; i++) begin
      a = (base + i) & MASK;
      px = mem_m.exists(a) ? mem_m[a] : 8'h00;
      exp_rd_q.push_back(a);
      sum += int'(px);
      exp_q.push_back(px);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic clear_obs();
    rx_q.delete(); rd_q.delete();
    bit_err = 0; max_gap = 0; have_prev = 1'b0; done_rises = 0; sync_err = 0;
  endtask

  task automatic start_frame(input int w, input int h, input int base);
    @(negedge clk_50);
    out_w = 16'(w); out_h = 16'(h); base_addr = AW'(base);
    start = 1'b1;
    have_prev = 1'b0;
    @(negedge clk_50);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      @(negedge clk_50);
      n++;
    end
    ok = (done === 1'b1);
    repeat (2) @(negedge clk_50);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; out_w = 16'd2; out_h = 16'd2;
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk_50);
    checks++;
    if ({uart_tx, busy, done, mem_rd_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: tx/busy/done/rd=%b required 1000", {uart_tx, busy, done, mem_rd_en});
    end
    checks++;
    if (mem_addr !== '0 || byte_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h count=%0d required 0 0", mem_addr, byte_count);
    end
    repeat (3) @(negedge clk_50);
    checks++;
    if (busy !== 1'b0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL start_in_reset: busy=%b reads=%0d required 0 0", busy, rd_q.size());
    end
  endtask

  task automatic test_basic();
    bit ok;
    int d;
    mem_m[32'h100] = 8'd10; mem_m[32'h101] = 8'd20;
    mem_m[32'h102] = 8'd30; mem_m[32'h103] = 8'd40;
    clear_obs();
    build_expected(2, 2, 32'h100);
    start_frame(2, 2, 32'h100);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: done=%b required 1", done); end
    d = frame_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL basic_frame: byte %0d got %h required %h (len %0d vs %0d)", d, rx_at(d), exp_at(d), rx_q.size(), exp_q.size());
    end
    checks++;
    if (rx_at(9) !== 8'h64) begin errors++; $display("FAIL basic_csum: got %h required 64", rx_at(9)); end
    checks++;
    if (byte_count !== 32'd10) begin errors++; $display("FAIL basic_count: got %0d required 10", byte_count); end
    d = addr_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL basic_reads: %0d reads, index %0d differs, required 4 at 0x100..0x103", rd_q.size(), d);
    end
    checks++;
    if (bit_err != 0 || max_gap > 3 || sync_err != 0) begin
      errors++;
      $display("FAIL basic_timing: bit_err=%0d gap=%0d sync_err=%0d required 0 <=3 0", bit_err, max_gap, sync_err);
    end
  endtask

  task automatic test_csum_wrap();
    bit ok;
    int d;
    mem_m[32'h2000] = 8'hFF; mem_m[32'h2001] = 8'h02;
    clear_obs();
    build_expected(2, 1, 32'h2000);
    start_frame(2, 1, 32'h2000);
    wait_done(ok);
    d = frame_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL wrap_frame: done=%b byte %0d got %h required %h", done, d, rx_at(d), exp_at(d));
    end
    checks++;
    if (rx_at(7) !== 8'h01) begin errors++; $display("FAIL wrap_csum: got %h required 01", rx_at(7)); end
  endtask

  task automatic test_empty();
    bit ok;
    int d;
    clear_obs();
    build_expected(0, 5, 32'h55);
    start_frame(0, 5, 32'h55);
    wait_done(ok);
    d = frame_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL empty_frame: done=%b byte %0d got %h required %h (len %0d)", done, d, rx_at(d), exp_at(d), rx_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin errors++; $display("FAIL empty_reads: got %0d required 0", rd_q.size()); end
    repeat (20) @(negedge clk_50);
    checks++;
    if (done !== 1'b1 || byte_count !== 32'd6 || bit_err != 0) begin
      errors++;
      $display("FAIL empty_hold: done=%b count=%0d bit_err=%0d required 1 6 0", done, byte_count, bit_err);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    int d;
    mem_m[32'h7FFFF] = 8'($urandom); mem_m[0] = 8'($urandom); mem_m[1] = 8'($urandom);
    clear_obs();
    build_expected(3, 1, 32'h7FFFF);
    start_frame(3, 1, 32'h7FFFF);
    wait_done(ok);
    d = addr_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL addr_wrap_reads: done=%b index %0d got %h required %h", done, d,
               (d >= 0 && d < rd_q.size()) ? rd_q[d] : -1, (d >= 0 && d < exp_rd_q.size()) ? exp_rd_q[d] : -1);
    end
    d = frame_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL addr_wrap_frame: byte %0d got %h required %h", d, rx_at(d), exp_at(d));
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int d;
    int base;
    base = $urandom & MASK;
    for (int i = 0; i < 6; i++) mem_m[(base + i) & MASK] = 8'($urandom);
    clear_obs();
    build_expected(3, 2, base);
    start_frame(3, 2, base);
    repeat (30) @(negedge clk_50);
    out_w = 16'd1; out_h = 16'd1; base_addr = '0; start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
    @(posedge clk_50);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    wait_done(ok);
    repeat (60) @(negedge clk_50);
    d = frame_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL busy_start_frame: done=%b byte %0d got %h required %h", done, d, rx_at(d), exp_at(d));
    end
    checks++;
    if (done_rises != 1 || busy !== 1'b0 || byte_count !== 32'd12) begin
      errors++;
      $display("FAIL busy_start_done: rises=%0d busy=%b count=%0d required 1 0 12", done_rises, busy, byte_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    int n;
    int base;
    base = $urandom & MASK;
    for (int i = 0; i < 3; i++) mem_m[(base + i) & MASK] = 8'($urandom);
    clear_obs();
    start_frame(3, 1, base);
    n = 0;
    while (!(rx_q.size() == 6 && dec_pos == 4 * CPB + 1) && n < 3000) begin
      @(negedge clk_50);
      #1;
      n++;
    end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL rst_mid_reach: rx=%0d pos=%0d required 6 %0d", rx_q.size(), dec_pos, 4 * CPB + 1); end
    rst_n = 1'b0;
    @(negedge clk_50);
    checks++;
    if ({uart_tx, busy, done} !== 3'b100 || byte_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_state: tx/busy/done=%b count=%0d required 100 0", {uart_tx, busy, done}, byte_count);
    end
    rd_q.delete();
    @(negedge clk_50);
    rst_n = 1'b1;
    repeat (80) @(negedge clk_50);
    checks++;
    if (rd_q.size() != 0 || busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_quiet: reads=%0d busy=%b tx=%b required 0 0 1", rd_q.size(), busy, uart_tx);
    end
    clear_obs();
    build_expected(3, 1, base);
    start_frame(3, 1, base);
    wait_done(ok);
    d = frame_diff();
    checks++;
    if (!ok || d != -1 || byte_count !== 32'd9) begin
      errors++;
      $display("FAIL rst_mid_restart: done=%b byte %0d got %h required %h count=%0d required 9", done, d, rx_at(d), exp_at(d), byte_count);
    end
  endtask

  task automatic test_random();
    bit ok;
    int d, a;
    int w, h, base;
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(0, 4);
      h = $urandom_range(0, 4);
      base = (k % 3 == 0) ? (MASK - $urandom_range(0, 3)) : ($urandom & MASK);
      for (int i = 0; i < w * h; i++) mem_m[(base + i) & MASK] = 8'($urandom);
      clear_obs();
      build_expected(w, h, base);
      start_frame(w, h, base);
      wait_done(ok);
      d = frame_diff();
      checks++;
      if (!ok || d != -1) begin
        errors++;
        $display("FAIL rand_frame[%0d]: w=%0d h=%0d byte %0d got %h required %h", k, w, h, d, rx_at(d), exp_at(d));
      end
      a = addr_diff();
      checks++;
      if (a != -1 || byte_count !== 32'(w * h + 6)) begin
        errors++;
        $display("FAIL rand_count[%0d]: reads=%0d required %0d count=%0d required %0d", k, rd_q.size(), w * h, byte_count, w * h + 6);
      end
      checks++;
      if (bit_err != 0 || max_gap > 3 || sync_err != 0 || done_rises != 1) begin
        errors++;
        $display("FAIL rand_timing[%0d]: bit_err=%0d gap=%0d sync=%0d rises=%0d required 0 <=3 0 1", k, bit_err, max_gap, sync_err, done_rises);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    mem_m[32'h300] = 8'h5A; mem_m[32'h301] = 8'hC3;
    clear_obs();
    start_frame(1, 1, 32'h300);
    wait_done(ok);
    clear_obs();
    build_expected(2, 1, 32'h300);
    start_frame(2, 1, 32'h300);
    checks++;
    if ({busy, done} !== 2'b10 || byte_count !== 32'd0 || mem_addr !== 19'h00300) begin
      errors++;
      $display("FAIL b2b_start: busy/done=%b count=%0d addr=%h required 10 0 00300", {busy, done}, byte_count, mem_addr);
    end
    wait_done(ok);
    d = frame_diff();
    checks++;
    if (!ok || d != -1) begin
      errors++;
      $display("FAIL b2b_frame: done=%b byte %0d got %h required %h", done, d, rx_at(d), exp_at(d));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csum_wrap();
    test_empty();
    test_addr_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
